// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue sitting between instruction memory
// and the IF/ID register. It issues one read at a time, starting at fetch_pc.
// Each returned word is queued together with its address + 4. A redirect from
// decode flushes the queue and restarts fetching at redirect_pc. If a read is
// still in flight when the redirect arrives, its response is discarded.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   redirect, redirect_pc    taken branch/jump from decode and its target
//   IF_ID_load               IF/ID consumes the head entry this cycle
//   imem_req, imem_addr      read request and address (held until imem_ack)
//   imem_ack, imem_rdata     read completion and instruction word (same cycle)
//   inst_valid               queue holds at least one entry
//   inst_out, pc4_out        head-entry instruction and address + 4 (0 when empty)
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        IF_ID_load,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] pc4_out
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;
  logic             imem_req_d;
  logic [31:0]      imem_addr_d;
  logic             inst_valid_d;
  logic [31:0]      inst_out_d, pc4_out_d;

  logic [31:0] inst_mem [DEPTH];
  logic [31:0] pc4_mem  [DEPTH];

  // Next-state, queue bookkeeping and next values of the registered outputs
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    imem_addr_d  = imem_addr;
    imem_req_d   = 1'b0;
    inst_valid_d = 1'b0;
    inst_out_d   = '0;
    pc4_out_d    = '0;

    // A redirect overrides any same-cycle push or pop
    pop  = IF_ID_load && (count_q != '0) && !redirect;
    push = (state_q == WAIT) && imem_ack && !redirect;

    if (redirect) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = redirect_pc;
    end else begin
      if (push) begin
        tail_d     = tail_q + PTR_W'(1);
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (pop) head_d = head_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    case (state_q)
      IDLE: if (!redirect && (count_q < FULL_CNT)) state_d = WAIT;
      WAIT: begin
        if (imem_ack) state_d = (!redirect && (count_d < FULL_CNT)) ? WAIT : IDLE;
        else if (redirect) state_d = DROP;
      end
      DROP: if (imem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A new address is launched on entry to WAIT or on a back-to-back push
    imem_req_d = (state_d != IDLE);
    if ((state_d == WAIT) && ((state_q == IDLE) || push)) imem_addr_d = fetch_pc_d;

    // Head of the queue after this edge; a push into the head slot bypasses storage
    inst_valid_d = (count_d != '0);
    if (count_d != '0) begin
      if (push && (tail_q == head_d)) begin
        inst_out_d = imem_rdata;
        pc4_out_d  = imem_addr + 32'd4;
      end else begin
        inst_out_d = inst_mem[head_d];
        pc4_out_d  = pc4_mem[head_d];
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      imem_req   <= 1'b0;
      imem_addr  <= '0;
      inst_valid <= 1'b0;
      inst_out   <= '0;
      pc4_out    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      imem_req   <= imem_req_d;
      imem_addr  <= imem_addr_d;
      inst_valid <= inst_valid_d;
      inst_out   <= inst_out_d;
      pc4_out    <= pc4_out_d;
    end
  end

  // Entry storage (no reset needed; an entry is only read after it has been written)
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[tail_q] <= imem_rdata;
      pc4_mem[tail_q]  <= imem_addr + 32'd4;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized and directed stimulus for fetch_queue. A memory
// responder returns the address as the data word. A reference model tracks the
// expected queue contents and the next fetch address, and a monitor checks the
// DUT outputs against that model every cycle.
module tb_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        IF_ID_load = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] pc4_out;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .IF_ID_load(IF_ID_load),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_out(inst_out), .pc4_out(pc4_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc4;
  } ent_t;

  ent_t        sb[$];          // expected queue contents, head at index 0
  logic [31:0] model_pc = RESET_PC;
  logic [31:0] req_addr = '0;
  bit          outstanding = 0;
  bit          stale = 0;
  bit          exp_req = 0;
  int          cnt_before = 0;

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: applies the inputs seen at each rising edge
  initial forever begin
    bit acked, was_stale;
    @(posedge clk or negedge rst);
    if (!rst) begin
      sb.delete();
      model_pc    = RESET_PC;
      outstanding = 0;
      stale       = 0;
      exp_req     = 0;
      cnt_before  = 0;
    end else begin
      was_stale = stale;
      acked     = imem_ack && outstanding;
      if (redirect) begin
        sb.delete();
        model_pc = redirect_pc;
        if (outstanding && !acked) stale = 1;
      end else if (acked && !stale) begin
        sb.push_back('{req_addr, req_addr + 32'd4});
        model_pc = model_pc + 32'd4;
      end
      if (acked) begin
        outstanding = 0;
        exp_req     = !was_stale && !redirect && (sb.size() < int'(DEPTH));
      end else if (outstanding) begin
        exp_req = 1;
      end else begin
        exp_req = !redirect && (cnt_before < int'(DEPTH));
      end
    end
  end

  // Monitor: compares outputs mid-cycle and retires entries the IF/ID stage takes
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("rst_req",   32'(imem_req),   32'd0);
      chk("rst_valid", 32'(inst_valid), 32'd0);
      chk("rst_addr",  imem_addr, 32'd0);
      chk("rst_inst",  inst_out,  32'd0);
      chk("rst_pc4",   pc4_out,   32'd0);
    end else begin
      cnt_before = sb.size();
      chk("inst_valid", 32'(inst_valid), 32'(sb.size() != 0));
      if (sb.size() != 0) begin
        chk("inst_out", inst_out, sb[0].inst);
        chk("pc4_out",  pc4_out,  sb[0].pc4);
      end else begin
        chk("inst_out_empty", inst_out, 32'd0);
        chk("pc4_out_empty",  pc4_out,  32'd0);
      end
      chk("imem_req", 32'(imem_req), 32'(exp_req));
      if (imem_req && !outstanding) begin
        chk("new_req_addr", imem_addr, model_pc);
        req_addr    = model_pc;
        outstanding = 1;
        stale       = 0;
      end else if (imem_req) begin
        chk("req_addr_hold", imem_addr, req_addr);
      end
      if (IF_ID_load && (sb.size() != 0) && !redirect) void'(sb.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit ack, input bit load, input bit redir, input logic [31:0] rpc);
    imem_ack    = ack;
    imem_rdata  = ack ? imem_addr : $urandom();
    IF_ID_load  = load;
    redirect    = redir;
    redirect_pc = rpc;
  endtask

  task automatic run_random(input int n, input int ack_pct, input int load_pct, input int redir_pct);
    for (int i = 0; i < n; i++) begin
      logic [31:0] rpc;
      step();
      rpc = ($urandom_range(7) == 0) ? 32'hFFFF_FFF4 : ($urandom() & 32'h0000_0FFC);
      set_in(imem_req && ($urandom_range(99) < 32'(ack_pct)),
             $urandom_range(99) < 32'(load_pct),
             $urandom_range(99) < 32'(redir_pct), rpc);
    end
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 32'd0);
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
  endtask

  // Redirect with ack matching imem_req always leaves the FSM idle
  task automatic settle(input logic [31:0] pc);
    step();
    set_in(imem_req, 0, 1, pc);
    step();
    set_in(0, 0, 0, 32'd0);
  endtask

  initial begin
    bit found;
    #1 rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;

    // Fill with no consumption, then one pop re-opens fetching at address 16
    repeat (14) begin step(); set_in(imem_req, 0, 0, 32'd0); end
    chk("full_req_idle", 32'(imem_req), 32'd0);
    chk("full_head", inst_out, 32'd0);
    step(); set_in(0, 1, 0, 32'd0);
    step(); set_in(0, 0, 0, 32'd0);
    step();
    chk("refill_addr", imem_addr, 32'd16);

    // Single-cycle memory with continuous consumption
    repeat (30) begin step(); set_in(imem_req, 1, 0, 32'd0); end

    // Redirect while waiting; response arrives three cycles later and is dropped
    settle(32'h0000_0040);
    step(); set_in(0, 0, 1, 32'h0000_0100);
    repeat (3) begin step(); set_in(0, 0, 0, 32'd0); end
    step(); set_in(1, 0, 0, 32'd0);
    step(); set_in(0, 0, 0, 32'd0);
    chk("drop_empty", 32'(inst_valid), 32'd0);
    step();
    chk("after_drop_addr", imem_addr, 32'h0000_0100);

    // Redirect in the same cycle as an ack and a pop with two entries queued
    settle(32'h0000_0080);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (sb.size() == 2 && imem_req) begin
        set_in(1, 1, 1, 32'h0000_0200);
        found = 1;
      end else begin
        set_in(imem_req, 0, 0, 32'd0);
      end
    end
    chk("two_entries_reached", 32'(found), 32'd1);
    step(); set_in(0, 0, 0, 32'd0);
    chk("flush_valid", 32'(inst_valid), 32'd0);
    step();
    chk("flush_next_addr", imem_addr, 32'h0000_0200);

    // Near-full operation with simultaneous push and pop wrapping the pointers
    repeat (12) begin step(); set_in(imem_req, 0, 0, 32'd0); end
    repeat (40) begin step(); set_in(imem_req, 1, 0, 32'd0); end

    // Fetch address wraps from 32'hFFFF_FFFC to 0
    settle(32'hFFFF_FFF8);
    repeat (8) begin step(); set_in(imem_req, 1, 0, 32'd0); end

    // Randomized traffic with varying rates
    for (int p = 0; p < 12; p++)
      run_random(200, $urandom_range(10, 100), $urandom_range(0, 100), $urandom_range(0, 8));

    // Asynchronous reset in the middle of an outstanding request
    settle(32'h0000_0300);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      set_in(0, 0, 0, 32'd0);
      found = imem_req;
    end
    chk("wait_before_reset", 32'(found), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_req",   32'(imem_req),   32'd0);
    chk("async_addr",  imem_addr,       32'd0);
    chk("async_valid", 32'(inst_valid), 32'd0);
    imem_ack = 1'b1;
    repeat (2) step();
    rst = 1'b1;
    step();
    set_in(0, 0, 0, 32'd0);
    chk("post_reset_req",  32'(imem_req), 32'd1);
    chk("post_reset_addr", imem_addr, RESET_PC);
    run_random(200, 60, 60, 3);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
